apb2axi_rdf_drain: RTL and testbench

APB-side consumer of the Read Data FIFO (RDF), in the PCLK domain. The APB register block starts a drain for one completed read tag. The block requests AXI-width beats from the RDF one at a time and splits each beat into APB-width words. It presents those words to the APB register block in order, and checks the beat count against the RDF last flag.

---
 rtl/apb2axi_pkg.sv | 22 ++
 rtl/apb2axi_rdf_drain_if.sv | 47 ++++
 rtl/apb2axi_beat_splitter.sv | 50 +++++
 rtl/apb2axi_rdf_drain.sv | 130 +++++++++++++
 tb/tb_apb2axi_rdf_drain.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_pkg.sv
// Shared APB-to-AXI bridge definitions used by the RDF drain logic.
package apb2axi_pkg;

    localparam int TAG_W      = 4;
    localparam int AXI_DATA_W = 64;
    localparam int APB_DATA_W = 32;

    function automatic int rdf_ratio(input int axi_w, input int apb_w);
        return axi_w / apb_w;
    endfunction

    localparam int RDF_RATIO = rdf_ratio(AXI_DATA_W, APB_DATA_W);

    typedef enum logic [2:0] {
        RDF_IDLE  = 3'd0,
        RDF_REQ   = 3'd1,
        RDF_WAIT  = 3'd2,
        RDF_SERVE = 3'd3,
        RDF_DONE  = 3'd4
    } rdf_drain_state_e;

endpackage

// File: rtl/apb2axi_rdf_drain_if.sv
// Signal bundle between the RDF drain block, the APB register block and the RDF.
interface apb2axi_rdf_drain_if #(
    parameter int AXI_DATA_W = apb2axi_pkg::AXI_DATA_W,
    parameter int APB_DATA_W = apb2axi_pkg::APB_DATA_W,
    parameter int TAG_W      = apb2axi_pkg::TAG_W
);
    logic                    drain_start;
    logic [TAG_W-1:0]        drain_tag;
    logic [7:0]              drain_beats;
    logic                    drain_busy;
    logic                    drain_done;
    logic                    drain_err;
    logic                    rdf_data_req;
    logic [TAG_W-1:0]        rdf_data_req_tag;
    logic                    rdf_data_valid;
    logic [AXI_DATA_W-1:0]   rdf_data_out;
    logic                    rdf_data_last;
    logic                    word_valid;
    logic [APB_DATA_W-1:0]   word_data;
    logic                    word_last;
    logic                    word_pop;
    apb2axi_pkg::rdf_drain_state_e dbg_state;

    // Handshakes: rdf_data_req and rdf_data_valid are single-cycle pulses with at
    // most one request outstanding; a word transfers in any cycle where both
    // word_valid and word_pop are high, and word_data holds until then.
    modport master (
        input  drain_start, drain_tag, drain_beats,
        output drain_busy, drain_done, drain_err,
        output rdf_data_req, rdf_data_req_tag,
        input  rdf_data_valid, rdf_data_out, rdf_data_last,
        output word_valid, word_data, word_last,
        input  word_pop,
        output dbg_state
    );

    modport slave (
        output drain_start, drain_tag, drain_beats,
        input  drain_busy, drain_done, drain_err,
        input  rdf_data_req, rdf_data_req_tag,
        output rdf_data_valid, rdf_data_out, rdf_data_last,
        input  word_valid, word_data, word_last,
        output word_pop,
        input  dbg_state
    );

endinterface

// File: rtl/apb2axi_beat_splitter.sv
// Holds one RDF beat and walks it out as APB-width words, lowest slice first.
module apb2axi_beat_splitter #(
    parameter int AXI_DATA_W = apb2axi_pkg::AXI_DATA_W,
    parameter int APB_DATA_W = apb2axi_pkg::APB_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [AXI_DATA_W-1:0] beat_i,
    input  logic                  serve_i,
    input  logic                  pop_i,
    output logic                  word_valid_o,
    output logic [APB_DATA_W-1:0] word_data_o,
    output logic                  slice_last_o
);
    import apb2axi_pkg::*;

    localparam int RATIO = rdf_ratio(AXI_DATA_W, APB_DATA_W);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [RATIO-1:0][APB_DATA_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;

    assign slice_last_o = (idx_q == IDX_W'(RATIO - 1));
    assign word_valid_o = serve_i;
    // Zero outside SERVE so a stale beat never shows on the word bus.
    assign word_data_o  = serve_i ? buf_q[idx_q] : '0;

    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (load_i) begin
            buf_d = beat_i;
            idx_d = '0;
        end else if (serve_i && pop_i) begin
            idx_d = slice_last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/apb2axi_rdf_drain.sv
// Drains one completed read tag from the RDF, one beat at a time, as APB words.
module apb2axi_rdf_drain #(
    parameter int AXI_DATA_W  = apb2axi_pkg::AXI_DATA_W,
    parameter int APB_DATA_W  = apb2axi_pkg::APB_DATA_W,
    parameter int TAG_W       = apb2axi_pkg::TAG_W,
    parameter int MAX_RSP_LAT = 15
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb2axi_rdf_drain_if.master bus
);
    import apb2axi_pkg::*;

    localparam int LAT_W = $clog2(MAX_RSP_LAT + 1);

    rdf_drain_state_e  state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [7:0]        beats_q, beats_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              beat_last_q, beat_last_d;
    logic              load;
    logic              serve;
    logic              slice_last;

    assign serve = (state_q == RDF_SERVE);

    apb2axi_beat_splitter #(
        .AXI_DATA_W (AXI_DATA_W),
        .APB_DATA_W (APB_DATA_W)
    ) u_splitter (
        .clk_i        (PCLK),
        .rst_ni       (PRESETn),
        .load_i       (load),
        .beat_i       (bus.rdf_data_out),
        .serve_i      (serve),
        .pop_i        (bus.word_pop),
        .word_valid_o (bus.word_valid),
        .word_data_o  (bus.word_data),
        .slice_last_o (slice_last)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        beat_last_d = beat_last_q;
        load        = 1'b0;
        case (state_q)
            RDF_IDLE: begin
                if (bus.drain_start) begin
                    tag_d       = bus.drain_tag;
                    beats_d     = bus.drain_beats;
                    beat_cnt_d  = 8'd0;
                    beat_last_d = 1'b0;
                    err_d       = (bus.drain_beats == 8'd0);
                    state_d     = (bus.drain_beats == 8'd0) ? RDF_DONE : RDF_REQ;
                end
            end
            RDF_REQ: begin
                wait_cnt_d = '0;
                state_d    = RDF_WAIT;
                if (bus.rdf_data_valid) err_d = 1'b1;
            end
            RDF_WAIT: begin
                if (bus.rdf_data_valid) begin
                    load        = 1'b1;
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    beat_last_d = bus.rdf_data_last;
                    state_d     = RDF_SERVE;
                end else if (wait_cnt_q == LAT_W'(MAX_RSP_LAT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RDF_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + LAT_W'(1);
                end
            end
            RDF_SERVE: begin
                if (bus.rdf_data_valid) err_d = 1'b1;
                // Beat count and last flag must agree once the beat is fully consumed.
                if (bus.word_pop && slice_last) begin
                    if (beat_cnt_q == beats_q) begin
                        if (!beat_last_q) err_d = 1'b1;
                        state_d = RDF_DONE;
                    end else if (beat_last_q) begin
                        err_d   = 1'b1;
                        state_d = RDF_DONE;
                    end else begin
                        state_d = RDF_REQ;
                    end
                end
            end
            RDF_DONE: state_d = RDF_IDLE;
            default:  state_d = RDF_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= RDF_IDLE;
            tag_q       <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            beat_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            beat_last_q <= beat_last_d;
        end
    end

    assign bus.drain_busy       = (state_q == RDF_REQ) || (state_q == RDF_WAIT) || serve;
    assign bus.drain_done       = (state_q == RDF_DONE);
    assign bus.drain_err        = err_q;
    assign bus.rdf_data_req     = (state_q == RDF_REQ);
    assign bus.rdf_data_req_tag = (state_q == RDF_REQ) ? tag_q : '0;
    assign bus.word_last        = serve && slice_last && (beat_cnt_q == beats_q);
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_apb2axi_rdf_drain.sv
// Directed bench for apb2axi_rdf_drain with hand-computed word expectations.
module tb_apb2axi_rdf_drain;

    logic PCLK;
    logic PRESETn;

    apb2axi_rdf_drain_if bus ();

    apb2axi_rdf_drain dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          req_cnt     = 0;
    int          done_cnt    = 0;
    logic [31:0] exp_q[$];

    // Clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(negedge PCLK) begin
        if (bus.rdf_data_req) req_cnt++;
        if (bus.drain_done)   done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    // Driver tasks
    task automatic start(input logic [3:0] tag, input logic [7:0] beats);
        bus.drain_start = 1'b1;
        bus.drain_tag   = tag;
        bus.drain_beats = beats;
        cyc();
        bus.drain_start = 1'b0;
    endtask

    task automatic wait_req(input logic [3:0] exp_tag);
        int n = 0;
        while (!bus.rdf_data_req && n < 20) begin
            cyc();
            n++;
        end
        chk("req_seen", 64'(bus.rdf_data_req), 64'(1'b1));
        chk("req_tag", 64'(bus.rdf_data_req_tag), 64'(exp_tag));
    endtask

    task automatic rdf_reply(input logic [63:0] data, input logic last);
        cyc();
        bus.rdf_data_valid = 1'b1;
        bus.rdf_data_out   = data;
        bus.rdf_data_last  = last;
        cyc();
        bus.rdf_data_valid = 1'b0;
        bus.rdf_data_last  = 1'b0;
        chk("capture_latency_word_valid", 64'(bus.word_valid), 64'(1'b1));
    endtask

    task automatic pop_word(input logic exp_last, input int gap);
        logic [31:0] exp_w;
        if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 64'(exp_q.size()), 64'(1));
            return;
        end
        exp_w = exp_q.pop_front();
        chk("word_valid", 64'(bus.word_valid), 64'(1'b1));
        chk("word_data", 64'(bus.word_data), 64'(exp_w));
        chk("word_last", 64'(bus.word_last), 64'(exp_last));
        for (int i = 0; i < gap; i++) begin
            cyc();
            chk("hold_word_data", 64'(bus.word_data), 64'(exp_w));
            chk("hold_no_req", 64'(bus.rdf_data_req), 64'(1'b0));
        end
        bus.word_pop = 1'b1;
        cyc();
        bus.word_pop = 1'b0;
    endtask

    task automatic push_beat(input logic [63:0] beat);
        exp_q.push_back(beat[31:0]);
        exp_q.push_back(beat[63:32]);
    endtask

    task automatic chk_end(input string tag, input logic exp_err);
        chk({tag, "_done"}, 64'(bus.drain_done), 64'(1'b1));
        chk({tag, "_busy_low"}, 64'(bus.drain_busy), 64'(1'b0));
        chk({tag, "_err"}, 64'(bus.drain_err), 64'(exp_err));
        cyc();
        chk({tag, "_done_pulse"}, 64'(bus.drain_done), 64'(1'b0));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.drain_busy), 64'(1'b0));
        chk({tag, "_done"}, 64'(bus.drain_done), 64'(1'b0));
        chk({tag, "_err"}, 64'(bus.drain_err), 64'(1'b0));
        chk({tag, "_req"}, 64'(bus.rdf_data_req), 64'(1'b0));
        chk({tag, "_req_tag"}, 64'(bus.rdf_data_req_tag), 64'(0));
        chk({tag, "_word_valid"}, 64'(bus.word_valid), 64'(1'b0));
        chk({tag, "_word_data"}, 64'(bus.word_data), 64'(0));
        chk({tag, "_word_last"}, 64'(bus.word_last), 64'(1'b0));
    endtask

    localparam logic [63:0] BEAT_A = 64'h1111_2222_3333_4444;
    localparam logic [63:0] BEAT_B = 64'h5555_6666_7777_8888;

    initial begin
        int req_base;
        int done_base;
        int n;

        PRESETn            = 1'b0;
        bus.drain_start    = 1'b0;
        bus.drain_tag      = '0;
        bus.drain_beats    = '0;
        bus.rdf_data_valid = 1'b0;
        bus.rdf_data_out   = '0;
        bus.rdf_data_last  = 1'b0;
        bus.word_pop       = 1'b0;
        repeat (3) cyc();
        chk_idle_zero("reset");
        PRESETn = 1'b1;
        cyc();
        chk_idle_zero("post_reset");

        // Normal 2-beat drain, pop every cycle
        req_base = req_cnt; done_base = done_cnt;
        push_beat(BEAT_A); push_beat(BEAT_B);
        chk("exp_word0", 64'(exp_q[0]), 64'h3333_4444);
        start(4'd3, 8'd2);
        chk("normal_busy", 64'(bus.drain_busy), 64'(1'b1));
        wait_req(4'd3);
        rdf_reply(BEAT_A, 1'b0);
        pop_word(1'b0, 0);
        pop_word(1'b0, 0);
        wait_req(4'd3);
        rdf_reply(BEAT_B, 1'b1);
        pop_word(1'b0, 0);
        pop_word(1'b1, 0);
        chk_end("normal", 1'b0);
        chk("normal_req_count", 64'(req_cnt - req_base), 64'(2));
        chk("normal_done_count", 64'(done_cnt - done_base), 64'(1));

        // Backpressure: five idle cycles before each pop
        req_base = req_cnt;
        push_beat(BEAT_A); push_beat(BEAT_B);
        start(4'd3, 8'd2);
        wait_req(4'd3);
        rdf_reply(BEAT_A, 1'b0);
        pop_word(1'b0, 5);
        pop_word(1'b0, 5);
        chk("bp_req_after_beat1", 64'(req_cnt - req_base), 64'(1));
        wait_req(4'd3);
        rdf_reply(BEAT_B, 1'b1);
        pop_word(1'b0, 5);
        pop_word(1'b1, 5);
        chk_end("bp", 1'b0);
        chk("bp_req_count", 64'(req_cnt - req_base), 64'(2));

        // Early last: 4 beats expected, last on beat 2
        req_base = req_cnt;
        push_beat(BEAT_A); push_beat(BEAT_B);
        start(4'd5, 8'd4);
        wait_req(4'd5);
        rdf_reply(BEAT_A, 1'b0);
        pop_word(1'b0, 0);
        pop_word(1'b0, 0);
        wait_req(4'd5);
        rdf_reply(BEAT_B, 1'b1);
        pop_word(1'b0, 0);
        pop_word(1'b0, 0);
        chk_end("early_last", 1'b1);
        repeat (4) cyc();
        chk("early_last_req_count", 64'(req_cnt - req_base), 64'(2));

        // Missing last on a single-beat drain
        push_beat(BEAT_B);
        start(4'd1, 8'd1);
        chk("missing_last_err_cleared", 64'(bus.drain_err), 64'(1'b0));
        wait_req(4'd1);
        rdf_reply(BEAT_B, 1'b0);
        pop_word(1'b0, 0);
        pop_word(1'b1, 0);
        chk_end("missing_last", 1'b1);

        // Zero-length drain: DONE right after start, no request
        req_base = req_cnt;
        start(4'd2, 8'd0);
        chk_end("zero_len", 1'b1);
        chk("zero_len_no_req", 64'(req_cnt - req_base), 64'(0));
        chk("zero_len_err_sticky", 64'(bus.drain_err), 64'(1'b1));

        // Timeout: no response after the request
        start(4'd4, 8'd1);
        chk("timeout_err_cleared", 64'(bus.drain_err), 64'(1'b0));
        wait_req(4'd4);
        n = 0;
        while (!bus.drain_done && n < 40) begin
            cyc();
            n++;
        end
        chk("timeout_cycles_req_to_done", 64'(n), 64'(16));
        chk_end("timeout", 1'b1);

        // Start while busy is ignored
        req_base = req_cnt; done_base = done_cnt;
        push_beat(BEAT_A); push_beat(BEAT_B);
        start(4'd3, 8'd2);
        wait_req(4'd3);
        rdf_reply(BEAT_A, 1'b0);
        start(4'd7, 8'd9);
        chk("busy_start_still_busy", 64'(bus.drain_busy), 64'(1'b1));
        pop_word(1'b0, 0);
        pop_word(1'b0, 0);
        wait_req(4'd3);
        rdf_reply(BEAT_B, 1'b1);
        pop_word(1'b0, 0);
        pop_word(1'b1, 0);
        chk_end("busy_start", 1'b0);
        chk("busy_start_req_count", 64'(req_cnt - req_base), 64'(2));
        chk("busy_start_done_count", 64'(done_cnt - done_base), 64'(1));

        // Reset while waiting for the RDF
        start(4'd6, 8'd1);
        wait_req(4'd6);
        cyc();
        PRESETn = 1'b0;
        #1;
        chk_idle_zero("async_reset");
        #1;
        PRESETn = 1'b1;
        cyc();
        bus.rdf_data_valid = 1'b1;
        bus.rdf_data_out   = BEAT_A;
        bus.rdf_data_last  = 1'b1;
        cyc();
        bus.rdf_data_valid = 1'b0;
        bus.rdf_data_last  = 1'b0;
        chk_idle_zero("late_rsp");
        cyc();
        chk_idle_zero("late_rsp_next");
        push_beat(BEAT_B);
        start(4'd6, 8'd1);
        wait_req(4'd6);
        rdf_reply(BEAT_B, 1'b1);
        pop_word(1'b0, 0);
        pop_word(1'b1, 0);
        chk_end("after_reset", 1'b0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
